// File: rtl/mult_div_if.sv
// mult_div_if: request/result bundle for mult_div_unit; master drives start/op/a/b/hi_we/lo_we/wdata, slave returns hi/lo/busy/done/div_by_zero
interface mult_div_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  modport master (output start, op, a, b, hi_we, lo_we, wdata, input hi, lo, busy, done, div_by_zero);
  modport slave (input start, op, a, b, hi_we, lo_we, wdata, output hi, lo, busy, done, div_by_zero);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: 34-cycle iterative MULT/MULTU/DIV/DIVU with HI/LO registers; ports clk, rst_n (async active-low), bus (mult_div_if.slave: start/op/a/b/hi_we/lo_we/wdata in, hi/lo/busy/done/div_by_zero out)
module mult_div_unit (
  input logic       clk,
  input logic       rst_n,
  mult_div_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;
  state_t state, state_nx;
  logic [1:0] op_r;
  logic [31:0] a_r, b_r, acc, q, dvs, hi_r, lo_r, mag_a, mag_b, diff, hi_fx, lo_fx;
  logic [5:0] cnt;
  logic neg_q, neg_r, dz, done_r, dbz_r, is_div, sgn, ge;
  logic [32:0] sum, shl;
  logic [63:0] prod;
  assign is_div = op_r[1];
  assign sgn = ~op_r[0];
  assign mag_a = sgn & a_r[31] ? -a_r : a_r;
  assign mag_b = sgn & b_r[31] ? -b_r : b_r;
  // multiply: acc:q holds the partial product, q[0] is the current multiplier bit
  assign sum = {1'b0, acc} + (q[0] ? {1'b0, dvs} : 33'd0);
  // divide: acc is the running remainder, q shifts dividend bits out and quotient bits in
  assign shl = {acc, q[31]};
  assign ge = shl >= {1'b0, dvs};
  assign diff = shl[31:0] - dvs;
  assign prod = neg_q ? -{acc, q} : {acc, q};
  assign hi_fx = is_div ? (dz ? a_r : (neg_r ? -acc : acc)) : prod[63:32];
  assign lo_fx = is_div ? (dz ? 32'hffffffff : (neg_q ? -q : q)) : prod[31:0];
  assign bus.hi = hi_r;
  assign bus.lo = lo_r;
  assign bus.busy = state != IDLE;
  assign bus.done = done_r;
  assign bus.div_by_zero = dbz_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE ? (bus.start ? PREP : IDLE) :
               state == PREP ? ITER :
               state == ITER ? (cnt == 6'd31 ? FIX : ITER) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      q <= '0;
      dvs <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      hi_r <= '0;
      lo_r <= '0;
      done_r <= 1'b0;
      dbz_r <= 1'b0;
    end else begin
      done_r <= state == FIX;
      dbz_r <= state == FIX && dz;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_r <= bus.op;
            a_r <= bus.a;
            b_r <= bus.b;
          end else begin
            if (bus.hi_we) hi_r <= bus.wdata;
            if (bus.lo_we) lo_r <= bus.wdata;
          end
        end
        PREP: begin
          acc <= '0;
          cnt <= '0;
          q <= is_div ? mag_a : mag_b;
          dvs <= is_div ? mag_b : mag_a;
          neg_q <= sgn & (a_r[31] ^ b_r[31]);
          neg_r <= sgn & is_div & a_r[31];
          dz <= is_div && b_r == 32'd0;
        end
        ITER: begin
          cnt <= cnt + 6'd1;
          if (is_div) begin
            acc <= ge ? diff : shl[31:0];
            q <= {q[30:0], ge};
          end else begin
            acc <= sum[32:1];
            q <= {sum[0], q[31:1]};
          end
        end
        default: begin
          hi_r <= hi_fx;
          lo_r <= lo_fx;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized scoreboard bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mult_div_if bus ();
  mult_div_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
  } exp_t;
  exp_t sbq[$];
  exp_t me;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prev_done = 1'b0;
  logic [31:0] hi_m, lo_m;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", n, act, exp, cyc);
    end
  endtask
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, qq, rr;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0;
    e.due = 0;
    if (op == 2'd0 || op == 2'd1) begin
      p = op == 2'd0 ? longint'(sa * sb) : longint'({32'd0, a}) * longint'({32'd0, b});
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi = a;
      e.lo = 32'hffffffff;
      e.dz = 1'b1;
    end else if (op == 2'd2) begin
      qq = sa / sb;
      rr = sa % sb;
      e.lo = qq[31:0];
      e.hi = rr[31:0];
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done && prev_done) chk("done_width", 1'b0, 1'b1);
      if (bus.done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual hi=%h lo=%h required no done", bus.hi, bus.lo);
        end else begin
          me = sbq.pop_front();
          chk("hi", bus.hi, me.hi);
          chk("lo", bus.lo, me.lo);
          chk("div_by_zero", bus.div_by_zero, me.dz);
          chk("latency", cyc, me.due);
          chk("busy_at_done", bus.busy, 1'b0);
        end
      end else if (bus.div_by_zero) chk("dbz_without_done", bus.div_by_zero, 1'b0);
    end
    prev_done = bus.done;
  end
  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", bus.busy, 1'b0);
  endtask
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit lw, input bit poke);
    exp_t e;
    e = model(op, a, b);
    e.due = cyc + 35;
    sbq.push_back(e);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.lo_we = lw;
    bus.wdata = 32'hdeadbeef;
    @(negedge clk);
    bus.start = 1'b0;
    bus.lo_we = 1'b0;
    chk("busy_after_start", bus.busy, 1'b1);
    chk("lo_hold_start", bus.lo, lo_m);
    if (poke) begin
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      bus.hi_we = 1'b1;
      bus.lo_we = 1'b1;
      bus.wdata = 32'h0badf00d;
      @(negedge clk);
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      chk("hi_hold_busy", bus.hi, hi_m);
      chk("lo_hold_busy", bus.lo, lo_m);
    end
    wait_idle();
    hi_m = e.hi;
    lo_m = e.lo;
    @(negedge clk);
  endtask
  initial begin
    exp_t e;
    logic [1:0] op;
    logic [31:0] a, b;
    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.a = '0;
    bus.b = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_dbz", bus.div_by_zero, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h12345678;
    @(negedge clk);
    bus.hi_we = 1'b0;
    chk("mthi", bus.hi, 32'h12345678);
    chk("mthi_lo_kept", bus.lo, 32'd0);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hcafef00d;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    chk("mthi_both", bus.hi, 32'hcafef00d);
    chk("mtlo_both", bus.lo, 32'hcafef00d);
    hi_m = 32'hcafef00d;
    lo_m = 32'hcafef00d;
    run(2'd0, 32'hfffffffe, 32'd3, 1'b1, 1'b0);
    run(2'd1, 32'hffffffff, 32'hffffffff, 1'b0, 1'b1);
    run(2'd2, 32'hfffffff9, 32'd2, 1'b0, 1'b0);
    run(2'd3, 32'd100, 32'd7, 1'b1, 1'b0);
    run(2'd3, 32'h64, 32'd0, 1'b0, 1'b0);
    run(2'd2, 32'h80000000, 32'hffffffff, 1'b0, 1'b1);
    run(2'd2, 32'hfffffff0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hffffffff;
        default: b = $urandom;
      endcase
      run(op, a, b, i % 3 == 0, i % 5 == 0);
    end
    e = model(2'd1, 32'd3, 32'd5);
    e.due = cyc + 35;
    sbq.push_back(e);
    e.due = cyc + 70;
    sbq.push_back(e);
    bus.start = 1'b1;
    bus.op = 2'd1;
    bus.a = 32'd3;
    bus.b = 32'd5;
    repeat (36) @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'd0;
    bus.a = 32'h7;
    bus.b = 32'h9;
    sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_dbz", bus.div_by_zero, 1'b0);
    sbq.delete();
    repeat (2) @(negedge clk);
    hi_m = 32'd0;
    lo_m = 32'd0;
    rst_n = 1'b1;
    run(2'd0, 32'hfffffffe, 32'd3, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
